// File: rtl/dac_play_pkg.sv
// dac_play_pkg: shared player state encoding and launch latency.
// Ports: none.
`timescale 1ns/1ps
package dac_play_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Launch sampled in cycle N puts beat 0 on the stream in cycle N+3.
    localparam int LAUNCH_LATENCY = 3;

endpackage

// File: rtl/dac_play_fifo.sv
// dac_play_fifo: sync prefetch FIFO with a registered head word.
// Ports: i_clk, i_rst, i_flush, i_push/i_data in, i_pop, o_head/o_head_vld, o_count.
`timescale 1ns/1ps
module dac_play_fifo
    import dac_play_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_head,
    output logic                    o_head_vld,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_buf [DEPTH];
    logic [DATA_WIDTH-1:0] r_head;
    logic                  r_head_vld;
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [PW:0]           r_bcnt;

    logic w_pop;
    logic w_head_free;
    logic w_buf_empty;
    logic w_buf_rd;
    logic w_buf_wr;

    assign w_pop       = i_pop & r_head_vld;
    assign w_head_free = !r_head_vld | w_pop;
    assign w_buf_empty = (r_bcnt == '0);
    // Head refills from the buffer first; an incoming word bypasses
    // straight into the head only when the buffer is empty.
    assign w_buf_rd    = w_head_free & !w_buf_empty;
    assign w_buf_wr    = i_push & !(w_head_free & w_buf_empty);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head_vld <= 1'b0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_bcnt     <= '0;
        end else begin
            if (w_head_free) begin
                r_head_vld <= !w_buf_empty | i_push;
            end
            if (w_buf_wr) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_buf_rd) begin
                r_rp <= r_rp + PW'(1);
            end
            r_bcnt <= r_bcnt + (PW+1)'(w_buf_wr) - (PW+1)'(w_buf_rd);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_head_free) begin
            if (!w_buf_empty) begin
                r_head <= r_buf[r_rp];
            end else if (i_push) begin
                r_head <= i_data;
            end
        end
        if (w_buf_wr) begin
            r_buf[r_wp] <= i_data;
        end
    end

    assign o_head     = r_head;
    assign o_head_vld = r_head_vld;
    assign o_count    = (PW+1)'(r_head_vld) + r_bcnt;

endmodule

// File: rtl/dac_playback.sv
// dac_playback: BRAM waveform player feeding one RF-DAC AXI4-Stream input.
// Ports: aclk/arst, wr_* load port, length/loop/trig_mode/start/stop/trig
//   control, busy_o/done_o/underflow_o status, m_axis_* DAC stream.
`timescale 1ns/1ps
module dac_playback
    import dac_play_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   wr_en,
    input  logic [ADDR_BITS-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [ADDR_BITS-1:0]   length_i,
    input  logic                   loop_i,
    input  logic                   trig_mode_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   trig_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   underflow_o,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_vld;

    state_t                r_state;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [ADDR_BITS-1:0]  r_len;
    logic                  r_loop;
    logic                  r_tvalid;
    logic                  r_presented;
    logic                  r_underflow;

    logic                  w_busy;
    logic                  w_stop;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_drain_fin;
    logic                  w_underrun;
    logic                  w_head_vld;
    logic [DATA_WIDTH-1:0] w_head;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_occ;

    assign w_busy   = (r_state != IDLE);
    assign w_stop   = stop_i & w_busy;
    assign w_accept = start_i & !stop_i & (r_state == IDLE);
    assign w_pop    = r_tvalid & m_axis_tready & w_head_vld;

    // Occupancy next cycle if nothing new is issued: queued beats plus
    // the beat leaving the BRAM register, minus this cycle's pop.
    assign w_occ   = {1'b0, w_count} + (CW+1)'(r_rd_vld) - (CW+1)'(w_pop);
    assign w_issue = (r_state == PLAY) & !stop_i
                   & (w_occ < (CW+1)'(FIFO_DEPTH));

    // Last owed beat is leaving the FIFO this cycle.
    assign w_drain_fin = (r_state == DRAIN) & !r_rd_vld
                       & ({1'b0, w_count} == (CW+1)'(w_pop));

    assign w_underrun = ((r_state == PLAY) || (r_state == DRAIN))
                      & r_presented & !w_head_vld;

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_addr];
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
        end
    end

    dac_play_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (aclk),
        .i_rst      (arst),
        .i_flush    (w_stop),
        .i_push     (r_rd_vld),
        .i_data     (r_rd_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_head_vld (w_head_vld),
        .o_count    (w_count)
    );

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_tvalid    <= 1'b0;
            r_presented <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tvalid <= 1'b1;
            if (((r_state == PLAY) || (r_state == DRAIN)) && w_head_vld) begin
                r_presented <= 1'b1;
            end
            if (w_underrun) begin
                r_underflow <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_len       <= length_i;
                        r_loop      <= loop_i;
                        r_addr      <= '0;
                        r_presented <= 1'b0;
                        r_underflow <= 1'b0;
                        r_state     <= trig_mode_i ? ARMED : PLAY;
                    end
                end
                ARMED: begin
                    if (stop_i) begin
                        r_state <= IDLE;
                    end else if (trig_i) begin
                        r_addr  <= '0;
                        r_state <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop_i) begin
                        r_state <= IDLE;
                    end else if (w_issue) begin
                        if (r_addr == r_len) begin
                            r_addr <= '0;
                            if (!r_loop) begin
                                r_state <= DRAIN;
                            end
                        end else begin
                            r_addr <= r_addr + ADDR_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (stop_i || w_drain_fin) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // done_o marks the cycle the player returns to IDLE, so a natural
    // finish lines up with the pop of the final beat.
    assign done_o        = !arst & (w_stop | w_drain_fin);
    assign busy_o        = w_busy;
    assign underflow_o   = r_underflow;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = w_head_vld ? w_head : '0;

endmodule

// File: tb/tb_dac_playback.sv
// tb_dac_playback: randomized bench with a cycle-level behavioural model.
// Ports: none.
`timescale 1ns/1ps
module tb_dac_playback;
    import dac_play_pkg::*;

    localparam int DW = 128;
    localparam int AB = 10;
    localparam int FD = 4;

    logic          aclk = 1'b0;
    logic          arst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AB-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AB-1:0] length_i = '0;
    logic          loop_i = 1'b0;
    logic          trig_mode_i = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          trig_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          underflow_o;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;

    always #5 aclk = ~aclk;

    dac_playback #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .FIFO_DEPTH (FD)
    ) dut (
        .aclk          (aclk),
        .arst          (arst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .length_i      (length_i),
        .loop_i        (loop_i),
        .trig_mode_i   (trig_mode_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .trig_i        (trig_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .underflow_o   (underflow_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural model: a launched waveform of len+1 beats shows beat k
    // at launch+LATENCY+k (modulo the length when looping), zeros
    // otherwise; finishing or stopping pulses done and returns to idle.
    typedef enum {M_IDLE, M_ARMED, M_ACT} mph_t;
    logic [DW-1:0] mem_m [1024];
    mph_t m_ph = M_IDLE;
    int   m_L = 0;
    int   m_len = 0;
    bit   m_loop = 0;
    bit   m_prev_rst = 0;
    bit   m_rst_seen = 0;
    bit   exact = 1;
    int   sb = 0;

    always @(negedge aclk) begin
        logic [DW-1:0] e_data;
        bit fin;
        int k;
        int tot;
        e_data = '0;
        fin = 0;
        k = 0;
        tot = m_len + 1;
        if (m_ph == M_ACT) begin
            k = cyc - m_L - LAUNCH_LATENCY;
            if (exact) begin
                if (k >= 0 && (m_loop || k < tot)) e_data = mem_m[k % tot];
                if (!m_loop && k == m_len) fin = 1;
            end
        end
        if (stop_i && m_ph != M_IDLE) fin = 1;
        if (m_rst_seen) begin
            chk("tvalid", DW'(m_axis_tvalid), DW'(!m_prev_rst));
            chk("busy", DW'(busy_o), DW'(m_ph != M_IDLE));
            chk("done", DW'(done_o), DW'(fin && !arst));
            chk("underflow", DW'(underflow_o), '0);
            if (m_ph == M_ACT && !exact) begin
                if (m_axis_tdata != '0 && m_axis_tready) begin
                    chk("beat_order", m_axis_tdata, mem_m[sb % tot]);
                    sb++;
                end else if (m_axis_tdata == '0 && sb > 0) begin
                    chk("beat_gap", m_axis_tdata, mem_m[sb % tot]);
                end
            end else begin
                chk("tdata", m_axis_tdata, e_data);
            end
        end
        if (wr_en) mem_m[wr_addr] = wr_data;
        if (arst) begin
            m_ph = M_IDLE;
            m_rst_seen = 1;
        end else if (fin) begin
            m_ph = M_IDLE;
        end else if (m_ph == M_IDLE) begin
            if (start_i && !stop_i) begin
                m_len  = int'(length_i);
                m_loop = loop_i;
                sb     = 0;
                if (trig_mode_i) begin
                    m_ph = M_ARMED;
                end else begin
                    m_ph = M_ACT;
                    m_L  = cyc;
                end
            end
        end else if (m_ph == M_ARMED && trig_i) begin
            m_ph = M_ACT;
            m_L  = cyc;
        end
        m_prev_rst = arst;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic at(input int c);
        for (int i = 0; i < 1000 && cyc < c; i++) step();
        @(negedge aclk);
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AB'(a);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic launch(input int len, input bit lp, input bit tm,
                          output int n);
        length_i    = AB'(len);
        loop_i      = lp;
        trig_mode_i = tm;
        start_i     = 1'b1;
        n           = cyc;
        step();
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int i = 0; i < budget && busy_o; i++) step();
        chk(nm, DW'(busy_o), '0);
    endtask

    logic [DW-1:0] ld [32];

    initial begin
        int n;
        int t;
        // Reset
        repeat (4) step();
        arst = 1'b0;
        step();
        at(cyc + 1);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_busy", DW'(busy_o), '0);
        step();

        // T1: beats 0..7, k in every sample, one shot
        for (int k = 0; k < 8; k++) load(k, {8{16'(k)}});
        launch(7, 0, 0, n);
        at(n + 4);
        chk("t1_beat1", m_axis_tdata, 128'h0001_0001_0001_0001_0001_0001_0001_0001);
        at(n + 10);
        chk("t1_beat7", m_axis_tdata, 128'h0007_0007_0007_0007_0007_0007_0007_0007);
        chk("t1_done", DW'(done_o), 128'd1);
        at(n + 11);
        chk("t1_busy_after", DW'(busy_o), '0);
        chk("t1_zero_after", m_axis_tdata, '0);
        step();

        // T2: loop over 4 beats for 100+ beats, then stop
        launch(3, 1, 0, n);
        at(n + 8);
        chk("t2_wrap", m_axis_tdata, 128'h0001_0001_0001_0001_0001_0001_0001_0001);
        for (int i = 0; i < 200 && cyc < n + 104; i++) step();
        stop_i = 1'b1;
        @(negedge aclk);
        chk("t2_stop_done", DW'(done_o), 128'd1);
        step();
        stop_i = 1'b0;
        @(negedge aclk);
        chk("t2_stop_zero", m_axis_tdata, '0);
        chk("t2_stop_busy", DW'(busy_o), '0);
        step();

        // T3: arm with a same-cycle trig (ignored), launch 20 cycles later
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        trig_i = 1'b1;
        launch(7, 0, 1, n);
        trig_i = 1'b0;
        repeat (19) step();
        trig_i = 1'b1;
        t = cyc;
        step();
        trig_i = 1'b0;
        at(t + 2);
        chk("t3_pre_zero", m_axis_tdata, '0);
        chk("t3_armed_busy", DW'(busy_o), 128'd1);
        at(t + 4);
        chk("t3_beat1", m_axis_tdata, 128'h0001_0001_0001_0001_0001_0001_0001_0001);
        step();
        wait_idle("t3_finish", 40);

        // Random waveform, every beat nonzero
        for (int k = 0; k < 32; k++) begin
            ld[k] = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
            load(k, ld[k]);
        end

        // T4: random tready while looping 16 beats
        exact = 0;
        m_axis_tready = 1'($urandom_range(0, 1));
        launch(15, 1, 0, n);
        repeat (400) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            step();
        end
        pulse_stop();
        exact = 1;
        m_axis_tready = 1'b1;
        step();
        chk("t4_progress", DW'(sb >= 100), 128'd1);

        // T5: reset mid-play, then replay the same memory
        launch(15, 1, 0, n);
        repeat (12) step();
        arst = 1'b1;
        repeat (2) step();
        arst = 1'b0;
        repeat (3) step();
        chk("t5_busy_post_rst", DW'(busy_o), '0);
        launch(15, 0, 0, n);
        at(n + 3);
        chk("t5_beat0", m_axis_tdata, ld[0]);
        step();
        wait_idle("t5_finish", 40);

        // T6: single beat, start while busy, stop+start in idle
        launch(0, 0, 0, n);
        length_i = AB'(5);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        at(n + 3);
        chk("t6_one_beat", m_axis_tdata, ld[0]);
        chk("t6_done", DW'(done_o), 128'd1);
        at(n + 4);
        chk("t6_busy_after", DW'(busy_o), '0);
        step();
        stop_i  = 1'b1;
        start_i = 1'b1;
        step();
        stop_i  = 1'b0;
        start_i = 1'b0;
        @(negedge aclk);
        chk("t6_stop_start", DW'(busy_o), '0);
        step();
        launch(0, 1, 0, n);
        repeat (10) step();
        pulse_stop();
        step();

        // Random sessions
        for (int s = 0; s < 12; s++) begin
            int len;
            bit lp;
            bit tm;
            len = $urandom_range(0, 31);
            lp  = 1'($urandom_range(0, 1));
            tm  = 1'($urandom_range(0, 1));
            launch(len, lp, tm, n);
            if (tm) begin
                repeat ($urandom_range(0, 5)) step();
                trig_i = 1'b1;
                step();
                trig_i = 1'b0;
            end
            repeat ($urandom_range(1, len + 8)) step();
            pulse_stop();
            step();
            wait_idle("rand_idle", 4);
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
